// File: rtl/scan_param_commit_if.sv
// Bus bundle for scan_param_commit: control-side requests/clears in,
// committed values and per-channel status flags out.
interface scan_param_commit_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32
);
    logic [NUM_CH-1:0]        req_in;
    logic [NUM_CH*DATA_W-1:0] data_in;
    logic                     commit_tick;
    logic [NUM_CH-1:0]        clear_overrun;
    logic [NUM_CH*DATA_W-1:0] active_out;
    logic [NUM_CH-1:0]        pending_out;
    logic [NUM_CH-1:0]        ack_out;
    logic [NUM_CH-1:0]        overrun_out;
    logic [NUM_CH-1:0]        timeout_out;

    modport master (
        output req_in, data_in, commit_tick, clear_overrun,
        input  active_out, pending_out, ack_out, overrun_out, timeout_out
    );

    modport slave (
        input  req_in, data_in, commit_tick, clear_overrun,
        output active_out, pending_out, ack_out, overrun_out, timeout_out
    );
endinterface

// File: rtl/scan_param_commit.sv
// scan_param_commit: per-channel shadow/active parameter staging.
// A request stages a value into the shadow register; the value moves to the
// active register only on a scan boundary (commit_tick), with a one-cycle ack.
// Optional watchdog forced commit: define SCAN_COMMIT_TIMEOUT_EN.
module scan_param_commit #(
    parameter int                NUM_CH      = 4,
    parameter int                DATA_W      = 32,
    parameter logic [DATA_W-1:0] RESET_VAL   = '0,
    parameter int                TIMEOUT_CYC = 1000
) (
    input  logic               clk_fast,
    input  logic               reset_n,
    scan_param_commit_if.slave bus
);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_e;

    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("scan_param_commit: TIMEOUT_CYC must be >= 2");
    end

    state_e            state_q  [NUM_CH];
    logic [DATA_W-1:0] shadow_q [NUM_CH];
    logic [DATA_W-1:0] active_q [NUM_CH];
    logic [NUM_CH-1:0] ack_q;
    logic [NUM_CH-1:0] ovr_q;
    logic [NUM_CH-1:0] ovr_d;
    logic [NUM_CH-1:0] commit_d;

`ifdef SCAN_COMMIT_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [NUM_CH-1:0] to_fire;
    logic [NUM_CH-1:0] to_q;
    logic [NUM_CH-1:0] to_d;
`endif

    // Per-channel commit decision and next value of the sticky flags (set beats clear)
    always_comb begin
        commit_d = '0;
        ovr_d    = '0;
`ifdef SCAN_COMMIT_TIMEOUT_EN
        to_fire  = '0;
        to_d     = '0;
`endif
        for (int unsigned i = 0; i < NUM_CH; i++) begin
`ifdef SCAN_COMMIT_TIMEOUT_EN
            // A fresh request restarts the watchdog, so it also suppresses the forced commit
            to_fire[i]  = (state_q[i] == PENDING) && !bus.commit_tick && !bus.req_in[i]
                          && (cnt_q[i] == CNT_W'(TIMEOUT_CYC - 1));
            to_d[i]     = to_fire[i] || (to_q[i] && !bus.clear_overrun[i]);
            commit_d[i] = (state_q[i] == PENDING) && (bus.commit_tick || to_fire[i]);
`else
            commit_d[i] = (state_q[i] == PENDING) && bus.commit_tick;
`endif
            ovr_d[i]    = ((state_q[i] == PENDING) && bus.req_in[i] && !bus.commit_tick)
                          || (ovr_q[i] && !bus.clear_overrun[i]);
        end
    end

    // Channel FSMs with their shadow/active registers, ack pulses and flags
    always_ff @(posedge clk_fast or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                state_q[i]  <= IDLE;
                shadow_q[i] <= RESET_VAL;
                active_q[i] <= RESET_VAL;
`ifdef SCAN_COMMIT_TIMEOUT_EN
                cnt_q[i]    <= '0;
`endif
            end
            ack_q <= '0;
            ovr_q <= '0;
`ifdef SCAN_COMMIT_TIMEOUT_EN
            to_q  <= '0;
`endif
        end else begin
            ack_q <= commit_d;
            ovr_q <= ovr_d;
`ifdef SCAN_COMMIT_TIMEOUT_EN
            to_q  <= to_d;
`endif
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                // Commit reads the old shadow, so a same-cycle request is staged behind it
                if (commit_d[i]) begin
                    active_q[i] <= shadow_q[i];
                end
                if (bus.req_in[i]) begin
                    shadow_q[i] <= bus.data_in[i*DATA_W +: DATA_W];
                end
                case (state_q[i])
                    IDLE: begin
                        if (bus.req_in[i]) begin
                            state_q[i] <= PENDING;
                        end
                    end
                    PENDING: begin
                        if (commit_d[i] && !bus.req_in[i]) begin
                            state_q[i] <= IDLE;
                        end
                    end
                    default: state_q[i] <= IDLE;
                endcase
`ifdef SCAN_COMMIT_TIMEOUT_EN
                if ((state_q[i] == IDLE) || bus.req_in[i] || commit_d[i]) begin
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
`endif
            end
        end
    end

    // Drive the bus outputs from the registered state
    always_comb begin
        bus.active_out  = '0;
        bus.pending_out = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            bus.active_out[i*DATA_W +: DATA_W] = active_q[i];
            bus.pending_out[i]                 = (state_q[i] == PENDING);
        end
        bus.ack_out     = ack_q;
        bus.overrun_out = ovr_q;
`ifdef SCAN_COMMIT_TIMEOUT_EN
        bus.timeout_out = to_q;
`else
        bus.timeout_out = '0;
`endif
    end

endmodule

// File: tb/tb_scan_param_commit.sv
// Directed testbench for scan_param_commit: table of per-cycle vectors plus
// hand-written reset and watchdog sequences.
module tb_scan_param_commit;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 32;
    localparam int TCYC   = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    scan_param_commit_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

    scan_param_commit #(
        .NUM_CH     (NUM_CH),
        .DATA_W     (DATA_W),
        .RESET_VAL  (32'h0),
        .TIMEOUT_CYC(TCYC)
    ) dut (
        .clk_fast(clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic [3:0]   req;
        logic [127:0] data;
        logic         tick;
        logic [3:0]   clr;
        logic [3:0]   pend;
        logic [3:0]   ack;
        logic [3:0]   ovr;
        logic [127:0] act;
    } vec_t;

    vec_t         vecs[$];
    logic [127:0] act_m;
    int           errors = 0;
    int           checks = 0;

    // Non-requesting channels see junk data, which they must ignore
    function automatic logic [127:0] dat(input int ch, input logic [31:0] v);
        logic [127:0] d;
        d = {4{32'hDEAD_BEEF}};
        d[ch*32 +: 32] = v;
        return d;
    endfunction

    task automatic add(input logic [3:0] req, input int ch, input logic [31:0] v,
                       input logic tick, input logic [3:0] clr,
                       input logic [3:0] pend, input logic [3:0] ack, input logic [3:0] ovr);
        vec_t e;
        e.req  = req;
        e.data = dat(ch, v);
        e.tick = tick;
        e.clr  = clr;
        e.pend = pend;
        e.ack  = ack;
        e.ovr  = ovr;
        e.act  = act_m;
        vecs.push_back(e);
    endtask

    task automatic drive(input logic [3:0] req, input logic [127:0] data,
                         input logic tick, input logic [3:0] clr);
        @(negedge clk);
        bus.req_in        = req;
        bus.data_in       = data;
        bus.commit_tick   = tick;
        bus.clear_overrun = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] pend, input logic [3:0] ack,
                       input logic [3:0] ovr, input logic [3:0] to, input logic [127:0] act);
        checks++;
        if ({bus.pending_out, bus.ack_out, bus.overrun_out, bus.timeout_out, bus.active_out}
            !== {pend, ack, ovr, to, act}) begin
            errors++;
            $display("FAIL %s: got pend=%b ack=%b ovr=%b to=%b act=%h ; want pend=%b ack=%b ovr=%b to=%b act=%h",
                     name, bus.pending_out, bus.ack_out, bus.overrun_out, bus.timeout_out,
                     bus.active_out, pend, ack, ovr, to, act);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        bus.req_in        = '0;
        bus.data_in       = '0;
        bus.commit_tick   = 1'b0;
        bus.clear_overrun = '0;
        act_m             = '0;

        // Asynchronous reset
        #2 rst_n = 1'b0;
        #1 chk("reset_async", 4'b0, 4'b0, 4'b0, 4'b0, 128'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table: one row per clock
        add(4'b0000, 0, 32'h0,      1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000); // idle tick ignored
        add(4'b0001, 0, 32'h1388,   1'b0, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        repeat (4) add(4'b0000, 0, 32'h0, 1'b0, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        act_m[0 +: 32] = 32'h1388;
        add(4'b0000, 0, 32'h0,      1'b1, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
        add(4'b0000, 0, 32'h0,      1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        // overrun on ch2
        add(4'b0100, 2, 32'hAAAA,   1'b0, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
        add(4'b0100, 2, 32'hBBBB,   1'b0, 4'b0000, 4'b0100, 4'b0000, 4'b0100);
        act_m[64 +: 32] = 32'hBBBB;
        add(4'b0000, 0, 32'h0,      1'b1, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
        add(4'b0000, 0, 32'h0,      1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0100);
        add(4'b0000, 0, 32'h0,      1'b0, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
        // simultaneous req + tick on pending ch3
        add(4'b1000, 3, 32'h10,     1'b0, 4'b0000, 4'b1000, 4'b0000, 4'b0000);
        act_m[96 +: 32] = 32'h10;
        add(4'b1000, 3, 32'h20,     1'b1, 4'b0000, 4'b1000, 4'b1000, 4'b0000);
        act_m[96 +: 32] = 32'h20;
        add(4'b0000, 0, 32'h0,      1'b1, 4'b0000, 4'b0000, 4'b1000, 4'b0000);
        add(4'b0000, 0, 32'h0,      1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        // req + tick on idle ch0: latch only
        add(4'b0001, 0, 32'h55,     1'b1, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        act_m[0 +: 32] = 32'h55;
        add(4'b0000, 0, 32'h0,      1'b1, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
        // overrun set and clear in the same cycle on ch1: set wins
        add(4'b0010, 1, 32'h1,      1'b0, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
        add(4'b0010, 1, 32'h2,      1'b0, 4'b0010, 4'b0010, 4'b0000, 4'b0010);
        add(4'b0000, 0, 32'h0,      1'b0, 4'b0010, 4'b0010, 4'b0000, 4'b0000);
        // one tick commits every pending channel
        add(4'b0100, 2, 32'h3,      1'b0, 4'b0000, 4'b0110, 4'b0000, 4'b0000);
        act_m[32 +: 32] = 32'h2;
        act_m[64 +: 32] = 32'h3;
        add(4'b0000, 0, 32'h0,      1'b1, 4'b0000, 4'b0000, 4'b0110, 4'b0000);
        // multi-cycle request level counts as overrun
        add(4'b0001, 0, 32'h9,      1'b0, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        add(4'b0001, 0, 32'hA,      1'b0, 4'b0000, 4'b0001, 4'b0000, 4'b0001);
        act_m[0 +: 32] = 32'hA;
        add(4'b0000, 0, 32'h0,      1'b1, 4'b0001, 4'b0000, 4'b0001, 4'b0000);
        add(4'b0000, 0, 32'h0,      1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        foreach (vecs[k]) begin
            drive(vecs[k].req, vecs[k].data, vecs[k].tick, vecs[k].clr);
            chk($sformatf("vec%0d", k), vecs[k].pend, vecs[k].ack, vecs[k].ovr, 4'b0000, vecs[k].act);
        end

`ifdef SCAN_COMMIT_TIMEOUT_EN
        // Watchdog forced commit after TCYC pending cycles
        drive(4'b0010, dat(1, 32'h77), 1'b0, 4'b0000);
        chk("to_req", 4'b0010, 4'b0000, 4'b0000, 4'b0000, act_m);
        repeat (TCYC - 1) drive(4'b0000, '0, 1'b0, 4'b0000);
        chk("to_before", 4'b0010, 4'b0000, 4'b0000, 4'b0000, act_m);
        drive(4'b0000, '0, 1'b0, 4'b0000);
        act_m[32 +: 32] = 32'h77;
        chk("to_fire", 4'b0000, 4'b0010, 4'b0000, 4'b0010, act_m);
        drive(4'b0000, '0, 1'b0, 4'b0010);
        chk("to_clear", 4'b0000, 4'b0000, 4'b0000, 4'b0000, act_m);
        // Real tick on the timeout cycle takes precedence
        drive(4'b0010, dat(1, 32'h78), 1'b0, 4'b0000);
        repeat (TCYC - 1) drive(4'b0000, '0, 1'b0, 4'b0000);
        drive(4'b0000, '0, 1'b1, 4'b0000);
        act_m[32 +: 32] = 32'h78;
        chk("to_tick_wins", 4'b0000, 4'b0010, 4'b0000, 4'b0000, act_m);
`endif

        // Reset mid-PENDING on ch1, then tick right after release
        drive(4'b0010, dat(1, 32'h99), 1'b0, 4'b0000);
        chk("pre_reset", 4'b0010, 4'b0000, 4'b0000, 4'b0000, act_m);
        @(negedge clk);
        bus.req_in = '0;
        #2 rst_n = 1'b0;
        #1 chk("reset_mid", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 128'h0);
        @(negedge clk);
        rst_n           = 1'b1;
        bus.commit_tick = 1'b1;
        @(posedge clk);
        #1 chk("post_reset_tick", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 128'h0);
        drive(4'b0000, '0, 1'b1, 4'b0000);
        chk("post_reset_tick2", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 128'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
